// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter: per-source FIFOs feed a registered register-file write port.
// Optional macro WB_FORWARD_EN adds fwd1/fwd2 forwarding outputs for decode.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          we3,
  output logic [AW-1:0] a3,
  output logic [DW-1:0] wd3,
  input  logic [AW-1:0] qa1,
  input  logic [AW-1:0] qa2,
  output logic          pend1,
  output logic          pend2,
  output logic          idle
`ifdef WB_FORWARD_EN
  ,
  output logic          fwd1_hit,
  output logic [DW-1:0] fwd1_data,
  output logic          fwd2_hit,
  output logic [DW-1:0] fwd2_data
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] f_addr [2][DEPTH];
  logic [DW-1:0] f_data [2][DEPTH];
  logic [PW-1:0] wr_ptr [2];
  logic [PW-1:0] rd_ptr [2];
  logic [CW-1:0] count  [2];
  logic [AW-1:0] in_addr [2];
  logic [DW-1:0] in_data [2];
  logic          last_grant;
  logic [1:0]    push, pop, ne;
  logic          grant_valid, grant_sel;
  logic [1:0]    m1, m2;
  logic          ws1, ws2;

  // Handshake: a transfer happens at a rising edge where valid && ready; ready depends
  // only on FIFO occupancy, and an addr==0 transfer is accepted but dropped.
  assign req0_ready = (count[0] < FULL);
  assign req1_ready = (count[1] < FULL);
  assign in_addr[0] = req0_addr;
  assign in_addr[1] = req1_addr;
  assign in_data[0] = req0_data;
  assign in_data[1] = req1_data;
  assign push[0] = req0_valid && req0_ready && (req0_addr != '0);
  assign push[1] = req1_valid && req1_ready && (req1_addr != '0);
  assign ne[0] = (count[0] != '0);
  assign ne[1] = (count[1] != '0);

  always_comb begin
    grant_valid = |ne;
    if (ne == 2'b11) grant_sel = ~last_grant;
    else             grant_sel = ne[1];
    pop[0] = grant_valid && !grant_sel;
    pop[1] = grant_valid && grant_sel;
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        f_addr[s][wr_ptr[s]] <= in_addr[s];
        f_data[s][wr_ptr[s]] <= in_data[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        count[s]  <= '0;
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
      end
      we3        <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
      last_grant <= 1'b1;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + 1'b1;
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + 1'b1;
          2'b01:   count[s] <= count[s] - 1'b1;
          default: count[s] <= count[s];
        endcase
      end
      we3 <= grant_valid;
      if (grant_valid) begin
        a3         <= f_addr[grant_sel][rd_ptr[grant_sel]];
        wd3        <= f_data[grant_sel][rd_ptr[grant_sel]];
        last_grant <= grant_sel;
      end
    end
  end

  // Per-FIFO match vectors over occupied slots only.
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < count[s]) begin
          if (f_addr[s][rd_ptr[s] + PW'(k)] == qa1) m1[s] = 1'b1;
          if (f_addr[s][rd_ptr[s] + PW'(k)] == qa2) m2[s] = 1'b1;
        end
      end
    end
  end

  assign ws1   = we3 && (a3 == qa1);
  assign ws2   = we3 && (a3 == qa2);
  assign pend1 = (qa1 != '0) && ((|m1) || ws1);
  assign pend2 = (qa2 != '0) && ((|m2) || ws2);
  assign idle  = (count[0] == '0) && (count[1] == '0) && !we3;

`ifdef WB_FORWARD_EN
  logic [DW-1:0] fd1 [2];
  logic [DW-1:0] fd2 [2];

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      fd1[s] = '0;
      fd2[s] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < count[s]) begin
          if (f_addr[s][rd_ptr[s] + PW'(k)] == qa1) fd1[s] = f_data[s][rd_ptr[s] + PW'(k)];
          if (f_addr[s][rd_ptr[s] + PW'(k)] == qa2) fd2[s] = f_data[s][rd_ptr[s] + PW'(k)];
        end
      end
    end
    fwd1_hit  = (qa1 != '0) && ((m1[0] ^ m1[1]) || ((m1 == 2'b00) && ws1));
    fwd2_hit  = (qa2 != '0) && ((m2[0] ^ m2[1]) || ((m2 == 2'b00) && ws2));
    fwd1_data = m1[0] ? fd1[0] : (m1[1] ? fd1[1] : wd3);
    fwd2_data = m2[0] ? fd2[0] : (m2[1] ? fd2[1] : wd3);
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter with a per-source expected-write scoreboard.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] qa1, qa2;
  logic          pend1, pend2, idle;
`ifdef WB_FORWARD_EN
  logic          fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd1_data, fwd2_data;
`endif

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .we3(we3), .a3(a3), .wd3(wd3),
    .qa1(qa1), .qa2(qa2), .pend1(pend1), .pend2(pend2), .idle(idle)
`ifdef WB_FORWARD_EN
    , .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [AW+DW-1:0] exp0_q[$];
  logic [AW+DW-1:0] exp1_q[$];
  int grant_log[$];
  logic [AW+DW-1:0] wb_key, wb_exp;
  logic sat_phase = 1'b0;
  logic saw_full0, saw_full1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver tasks: hold valid until accepted, return on the following negedge
  task automatic send0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done = 0;
    req0_valid = 1'b1;
    req0_addr = a;
    req0_data = d;
    for (int t = 0; t < 64 && !done; t++) begin
      @(posedge clk);
      if (req0_ready) done = 1;
    end
    if (!done) check_eq("send0_timeout", req0_ready, 1);
    @(negedge clk);
  endtask

  task automatic send1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done = 0;
    req1_valid = 1'b1;
    req1_addr = a;
    req1_data = d;
    for (int t = 0; t < 64 && !done; t++) begin
      @(posedge clk);
      if (req1_ready) done = 1;
    end
    if (!done) check_eq("send1_timeout", req1_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (idle) done = 1;
    end
    check_eq(tag, idle, 1);
  endtask

  // scoreboard: record accepted non-x0 transfers per source
  always @(posedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready && req0_addr != '0) exp0_q.push_back({req0_addr, req0_data});
      if (req1_valid && req1_ready && req1_addr != '0) exp1_q.push_back({req1_addr, req1_data});
    end
  end

  // scoreboard: every write must be the oldest outstanding entry of one source
  always @(negedge clk) begin
    if (rst_n && we3) begin
      wb_key = {a3, wd3};
      if (exp0_q.size() > 0 && exp0_q[0] == wb_key) begin
        wb_exp = exp0_q.pop_front();
        grant_log.push_back(0);
        check_eq("wb_write", wb_key, wb_exp);
      end else if (exp1_q.size() > 0) begin
        wb_exp = exp1_q.pop_front();
        grant_log.push_back(1);
        check_eq("wb_write", wb_key, wb_exp);
      end else begin
        check_eq("wb_unexpected", we3, 0);
      end
    end
    if (sat_phase) begin
      if (!req0_ready) saw_full0 = 1'b1;
      if (!req1_ready) saw_full1 = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    qa1 = '0; qa2 = '0;
    saw_full0 = 1'b0; saw_full1 = 1'b0;

    // reset state
    do_reset();
    #1;
    check_eq("rst_we3", we3, 0);
    check_eq("rst_a3", a3, 0);
    check_eq("rst_wd3", wd3, 0);
    check_eq("rst_ready0", req0_ready, 1);
    check_eq("rst_ready1", req1_ready, 1);
    check_eq("rst_idle", idle, 1);

    // single write latency and pending window
    qa1 = 5;
    #1 check_eq("t1_pend_before", pend1, 0);
    send0(5, 32'hDEADBEEF);
    req0_valid = 1'b0;
    #1;
    check_eq("t1_pend_fifo", pend1, 1);
    check_eq("t1_busy", idle, 0);
    @(negedge clk); #1;
    check_eq("t1_we3", we3, 1);
    check_eq("t1_a3", a3, 5);
    check_eq("t1_wd3", wd3, 32'hDEADBEEF);
    check_eq("t1_pend_ws", pend1, 1);
    @(negedge clk); #1;
    check_eq("t1_we3_off", we3, 0);
    check_eq("t1_pend_clear", pend1, 0);
    check_eq("t1_idle", idle, 1);

    // both sources saturated: strict alternation starting with req0
    do_reset();
    grant_log.delete();
    qa1 = '0;
    saw_full0 = 1'b0; saw_full1 = 1'b0;
    sat_phase = 1'b1;
    fork
      begin
        for (int i = 1; i <= 8; i++) send0(AW'(i), DW'(32'h1000 + i));
        req0_valid = 1'b0;
      end
      begin
        for (int i = 9; i <= 16; i++) send1(AW'(i), DW'(32'h2000 + i));
        req1_valid = 1'b0;
      end
    join
    wait_idle("t2_drain");
    sat_phase = 1'b0;
    check_eq("t2_count", grant_log.size(), 16);
    for (int i = 0; i < grant_log.size(); i++) check_eq("t2_alternate", grant_log[i], i % 2);
    check_eq("t2_full0", saw_full0, 1);
    check_eq("t2_full1", saw_full1, 1);

    // x0 transfer is accepted but never written
    @(negedge clk);
    qa1 = '0; qa2 = '0;
    req1_valid = 1'b1; req1_addr = '0; req1_data = 32'h1234;
    #1 check_eq("x0_ready", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check_eq("x0_idle", idle, 1);
      check_eq("x0_pend", pend1, 0);
    end

    // reset mid-operation discards buffered writes
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 3; req0_data = 32'h33;
    @(negedge clk);
    req0_addr = 4; req0_data = 32'h44;
    rst_n = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b0;
    qa1 = 3; qa2 = 4;
    #1;
    check_eq("mr_we3", we3, 0);
    check_eq("mr_ready0", req0_ready, 1);
    check_eq("mr_idle", idle, 1);
    check_eq("mr_pend1", pend1, 0);
    check_eq("mr_pend2", pend2, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_eq("mr_no_we3", we3, 0);
    end

    // push and pop on FIFO0 at DEPTH-1 occupancy
    qa1 = '0; qa2 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req0_addr = AW'(17 + i);
      req0_data = DW'(32'h5000 + i);
      #1 check_eq("pp_ready0", req0_ready, 1);
      if (i >= 2) check_eq("pp_we3", we3, 1);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_idle("pp_drain");

    // hazard / forwarding window
    do_reset();
    req0_valid = 1'b1; req0_addr = 20; req0_data = 32'h20;
    req1_valid = 1'b1; req1_addr = 7;  req1_data = 32'hA;
    @(negedge clk);
    req0_addr = 21; req0_data = 32'h21;
    req1_addr = 7;  req1_data = 32'hB;
    @(negedge clk);
    req0_addr = 7; req0_data = 32'hC;
    req1_valid = 1'b0;
    qa1 = 7; qa2 = 21;
    #1;
    check_eq("fw_pend1_a", pend1, 1);
    check_eq("fw_pend2_a", pend2, 1);
`ifdef WB_FORWARD_EN
    check_eq("fw_hit1_a", fwd1_hit, 1);
    check_eq("fw_data1_a", fwd1_data, 32'hB);
    check_eq("fw_hit2_a", fwd2_hit, 1);
    check_eq("fw_data2_a", fwd2_data, 32'h21);
`endif
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check_eq("fw_pend1_b", pend1, 1);
`ifdef WB_FORWARD_EN
    check_eq("fw_hit1_b", fwd1_hit, 0);
`endif
    @(negedge clk); #1;
`ifdef WB_FORWARD_EN
    check_eq("fw_hit1_c", fwd1_hit, 0);
`endif
    check_eq("fw_pend1_c", pend1, 1);
    @(negedge clk); #1;
`ifdef WB_FORWARD_EN
    check_eq("fw_hit1_d", fwd1_hit, 1);
    check_eq("fw_data1_d", fwd1_data, 32'hC);
`endif
    check_eq("fw_pend2_d", pend2, 0);
    @(negedge clk); #1;
    check_eq("fw_pend1_e", pend1, 1);
    check_eq("fw_ws_a3", a3, 7);
`ifdef WB_FORWARD_EN
    check_eq("fw_hit1_e", fwd1_hit, 1);
    check_eq("fw_data1_e", fwd1_data, 32'hC);
`endif
    @(negedge clk); #1;
    check_eq("fw_pend1_f", pend1, 0);
    wait_idle("fw_drain");

    // final report
    check_eq("final_q0_empty", exp0_q.size(), 0);
    check_eq("final_q1_empty", exp1_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
